// File: rtl/div_pkg.sv
// Shared types and sizing for the multi-cycle DIV/DIVU unit.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_sign_fix.sv
// Sign handling around the unsigned divider core: operand magnitudes and sign
// flags on the way in, conditional negation of quotient/remainder on the way out.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_abs_o,
    output logic [WIDTH-1:0] b_abs_o,
    output logic             q_neg_o,
    output logic             r_neg_o,
    input  logic             q_neg_i,
    input  logic             r_neg_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] rem_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg   = signed_div_i & a_i[WIDTH-1];
        b_neg   = signed_div_i & b_i[WIDTH-1];
        a_abs_o = a_neg ? (~a_i + 1'b1) : a_i;
        b_abs_o = b_neg ? (~b_i + 1'b1) : b_i;
        q_neg_o = a_neg ^ b_neg;
        r_neg_o = a_neg;
        quo_o   = q_neg_i ? (~quo_i + 1'b1) : quo_i;
        rem_o   = r_neg_i ? (~rem_i + 1'b1) : rem_i;
    end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result = {HI=remainder, LO=quotient}.
// Define DIV_ZERO_FAST_EN to let a zero divisor skip CALC and finish the cycle after start.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    div_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               q_neg_in, r_neg_in;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .signed_div_i (signed_div),
        .a_i          (a),
        .b_i          (b),
        .a_abs_o      (a_abs),
        .b_abs_o      (b_abs),
        .q_neg_o      (q_neg_in),
        .r_neg_o      (r_neg_in),
        .q_neg_i      (q_neg_q),
        .r_neg_i      (r_neg_q),
        .quo_i        (step_quo),
        .rem_i        (step_rem),
        .quo_o        (quo_fix),
        .rem_o        (rem_fix)
    );

    // Partial remainder stays below the divisor, so a (WIDTH+1)-bit trial
    // difference is wide enough and its MSB is the borrow.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        res_d   = res_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvs_d   = b_abs;
                    q_neg_d = q_neg_in;
                    r_neg_d = r_neg_in;
                    dz_d    = (b == '0);
                    cnt_d   = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (b == '0) begin
                        state_d = DIV_DONE;
                        res_d   = {a, ALL_ONES};
                    end else begin
                        state_d = DIV_CALC;
                    end
`else
                    state_d = DIV_CALC;
`endif
                end
            end
            DIV_CALC: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    // Divide-by-zero: remainder already recovers a after sign fix; only LO is forced.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_DONE;
                        res_d   = {rem_fix, dz_q ? ALL_ONES : quo_fix};
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end

    assign result = res_q;
    assign ready  = (state_q == DIV_DONE);
    assign busy   = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor checks them on ready.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    typedef struct {
        logic [2*W-1:0] res;
        int unsigned    due;
    } exp_t;

    exp_t           sbq[$];
    exp_t           mon_e;
    int unsigned    cyc = 0;
    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sgn);
        longint sx, sy, q, r;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int unsigned lat(input logic [W-1:0] y);
`ifdef DIV_ZERO_FAST_EN
        return (y == 0) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (result !== mon_e.res) begin
                    errors++;
                    $display("FAIL result: got %h expected %h (cycle %0d)", result, mon_e.res, cyc);
                end
                checks++;
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL latency: ready at cycle %0d expected cycle %0d", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
        exp_t e;
        e.res = ref_div(x, y, sgn);
        e.due = cyc + lat(y);
        sbq.push_back(e);
        last_exp = e.res;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
        @(negedge clk);
        a = x; b = y; signed_div = sgn; start = 1'b1;
        push_exp(x, y, sgn);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0 && sbq.size() == 0) begin
                checks++;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL timeout: busy=%b pending=%0d after 200 cycles, expected idle", busy, sbq.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_flags", {62'd0, busy, ready}, '0);
        rst = 1'b0;

        // DIVU 100/7 with busy-length measurement
        issue(32'd100, 32'd7, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(W + 1));
        wait_idle();

        issue(32'hFFFF_FFF9, 32'd2, 1'b1); wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0); wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(32'h1234_5678, 32'd0, 1'b0); wait_idle();
        issue(32'h8765_4321, 32'd0, 1'b1); wait_idle();

        // annul in CALC cycle 10
        issue(32'hDEAD_BEEF, 32'd3, 1'b0);
        void'(sbq.pop_back());
        repeat (8) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy", {63'd0, busy}, '0);
        check("annul_result", result, ref_div(32'h8765_4321, 32'd0, 1'b1));
        last_exp = ref_div(32'h8765_4321, 32'd0, 1'b1);
        repeat (40) @(negedge clk);

        // start together with annul in IDLE
        @(negedge clk);
        a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check("start_annul_busy", {63'd0, busy}, '0);
        repeat (40) @(negedge clk);
        check("start_annul_result", result, last_exp);

        // reset at CALC cycle 20
        issue(32'hCAFE_F00D, 32'd9, 1'b0);
        void'(sbq.pop_back());
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_result", result, '0);
        check("rst_mid_flags", {62'd0, busy, ready}, '0);
        last_exp = '0;
        repeat (40) @(negedge clk);
        issue(32'd1000, 32'd33, 1'b0); wait_idle();

        // back-to-back, start held high while busy
        @(negedge clk);
        a = 32'h0000_FFFF; b = 32'd16; signed_div = 1'b0; start = 1'b1;
        push_exp(32'h0000_FFFF, 32'd16, 1'b0);
        @(negedge clk);
        a = 32'h7777_7777; b = 32'd77;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        push_exp(32'h7777_7777, 32'd77, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            issue(ra, rb, $urandom_range(0, 1));
            wait_idle();
        end

        check("final_result_held", result, last_exp);
        check("queue_empty", 64'(sbq.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in the execute stage beside the combinational ALU and consumes the same 32-bit operand buses.
- Produces the HI (remainder) and LO (quotient) pair and stalls the pipeline through a start/ready handshake.
- Pipeline control may abandon an operation with annul (exception or branch flush).

Parameters:
- WIDTH, 32, operand width in bits; the result is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- a  in  WIDTH  dividend (rs)
- b  in  WIDTH  divisor (rt)
- annul  in  1  abandon the current or requested operation
- result  out  2*WIDTH  {remainder -> HI, quotient -> LO}
- ready  out  1  one-cycle pulse; result is valid
- busy  out  1  high in CALC and DONE; the pipeline stalls on busy & ~ready

Behaviour:
- Reset: state IDLE, result = 0, ready = 0, busy = 0. Reset mid-operation aborts immediately; no ready pulse follows.
- States:
  - IDLE: start & ~annul latches the operands, takes absolute values when signed_div = 1, records the quotient and remainder signs, clears the iteration counter, then goes to CALC.
  - CALC: one restoring step per cycle, exactly WIDTH cycles. Each step shifts {rem, quo} left by 1 and trial-subtracts the divisor from a (WIDTH+1)-bit partial remainder. A non-negative trial commits and sets the quotient LSB to 1; otherwise it restores and sets the LSB to 0. After step WIDTH, apply sign correction and go to DONE.
  - DONE: ready = 1 for exactly this one cycle, result updated, then IDLE.
- Latency: ready is high in the cycle WIDTH+1 cycles after the cycle that sampled start (33 for WIDTH = 32).
- Result handling: result is held stable from the DONE cycle until the next DONE. It is not cleared by annul or by a new start.
- Sign rules when signed_div = 1:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Divide by zero (b == 0), either signedness: result = {a, all-ones}. The unit still takes the full latency unless the optional feature below is enabled.
- start is ignored while busy; the operand inputs are don't-care after the start cycle.
- annul:
  - In CALC: next state is IDLE, no ready pulse, result unchanged.
  - Together with start in IDLE: annul wins and the state stays IDLE.
  - In DONE: ready is still asserted (the result is already committed); the pipeline discards it.
- Back-to-back operations: start may be accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: when b == 0 at start, IDLE goes straight to DONE. ready pulses on the cycle after start, with result = {a, all-ones}.
- Undefined: a zero divisor runs the full WIDTH-cycle CALC and produces the same result value at normal latency.
- The defined/undefined choice affects latency only, never the result value.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {DIV_IDLE, DIV_CALC, DIV_DONE}
  - localparam DIV_WIDTH = 32
  - localparam DIV_CNT_W = $clog2(DIV_WIDTH+1)
- Sub-module div_sign_fix (combinational):
  - input side: absolute-value extraction and sign flags;
  - output side: conditional two's-complement negation of quotient and remainder.
  - Instantiated once; keeps the datapath FSM clean.

Test Plan:
- DIVU a=100, b=7, start 1 cycle -> busy for 33 cycles, ready pulse once at cycle 33, result = {0x00000002, 0x0000000E}.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3); same operands with DIVU -> {0x00000001, 0x7FFFFFFC}.
- DIV a=0x80000000, b=0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU a=0x12345678, b=0 -> {0x12345678, 0xFFFFFFFF}, ready at 33 (at cycle 1 with DIV_ZERO_FAST_EN).
- annul at cycle 10 of CALC -> IDLE next cycle, no ready pulse, result keeps its previous value; start+annul in IDLE -> busy stays 0.
- rst asserted at cycle 20 of CALC -> next cycle result = 0, busy = 0, ready = 0; a new start afterwards completes normally.
- Two back-to-back DIVUs (start pulsed in the IDLE cycle after DONE, plus start held high while busy) -> exactly two ready pulses 34 cycles apart; the second result matches the second operands.
